// File: rtl/bridge_keys_pkg.sv
// Shared constants for the Bridge Companion button-to-ps2_key bridge:
// button count, scancode table and emitter state encoding.
package bridge_keys_pkg;

    localparam int NUM_BRIDGE_BTN = 12;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GAP  = 1'b1
    } emit_state_e;

    // Index order matches the keyboard decoder's `inputs` vector; unknown indices emit 00.
    function automatic logic [7:0] bridge_code(input int idx);
        logic [7:0] code;
        case (idx)
            0:       code = 8'h1C;  // pass
            1:       code = 8'h1A;  // spades
            2:       code = 8'h2A;  // clubs
            3:       code = 8'h2B;  // redouble
            4:       code = 8'h1B;  // no trump
            5:       code = 8'h22;  // hearts / up
            6:       code = 8'h14;  // play yes
            7:       code = 8'h66;  // back
            8:       code = 8'h23;  // double
            9:       code = 8'h21;  // diamonds / down
            10:      code = 8'h16;  // start
            11:      code = 8'h11;  // play no
            default: code = 8'h00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit read/write pointers and a registered
// occupancy count. Callers never pop when empty nor push when full.
module sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   lvl_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      lvl_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + ONE;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + ONE;
            if (push_i && !pop_i)      lvl_q <= lvl_q + ONE;
            else if (pop_i && !push_i) lvl_q <= lvl_q - ONE;
        end
    end

    // Storage carries no reset: contents are only visible behind a valid pointer.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign lvl_o   = lvl_q;

endmodule

// File: rtl/joy_to_ps2_key.sv
// Converts level button states into paced ps2_key toggle words: edge detect,
// lowest-index-first event queueing, and a gap-timed emitter.
module joy_to_ps2_key
    import bridge_keys_pkg::*;
#(
    parameter int NUM_BTN    = NUM_BRIDGE_BTN,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_BTN-1:0]            btn,
    output logic [10:0]                   ps2_key,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl,
    output emit_state_e                   dbg_state
);

    localparam int IW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int EW = IW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    logic [NUM_BTN-1:0] btn_s_q, btn_last_q, btn_last_d, diff;
    logic [IW-1:0]      enc_idx;
    logic               enc_hit;
    logic               push, pop;
    logic               fifo_full, fifo_empty;
    logic [EW-1:0]      wr_data, rd_data;

    emit_state_e        state_q, state_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [10:0]        ps2_key_q, ps2_key_d;

    assign diff = btn_s_q ^ btn_last_q;

    // Lowest pending index wins; higher ones wait for later cycles.
    always_comb begin
        enc_idx = '0;
        enc_hit = 1'b0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (diff[i]) begin
                enc_idx = IW'(i);
                enc_hit = 1'b1;
            end
        end
    end

    assign push    = enc_hit & ~fifo_full;
    assign wr_data = {enc_idx, btn_s_q[enc_idx]};

    always_comb begin
        btn_last_d = btn_last_q;
        if (push) btn_last_d[enc_idx] = btn_s_q[enc_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_s_q    <= '0;
            btn_last_q <= '0;
        end else begin
            btn_s_q    <= btn;
            btn_last_q <= btn_last_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i (wr_data),
        .pop_i   (pop),
        .rdata_o (rd_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .lvl_o   (fifo_lvl)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            ps2_key_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            ps2_key_q <= ps2_key_d;
        end
    end

    // GAP is left as the counter reaches zero so toggles land exactly GAP_CYCLES apart.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = (GAP_CYCLES > 1) ? GAP : IDLE;
            GAP:     if (gap_cnt_q <= GW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        ps2_key_d = ps2_key_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    ps2_key_d = {~ps2_key_q[10], rd_data[0], 1'b0,
                                 bridge_code(int'(rd_data[EW-1:1]))};
                    gap_cnt_d = GAP_LOAD;
                end
            end
            GAP:     gap_cnt_d = gap_cnt_q - GW'(1);
            default: gap_cnt_d = '0;
        endcase
    end

    assign ps2_key   = ps2_key_q;
    assign busy      = (fifo_lvl != '0) | (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_joy_to_ps2_key.sv
// Bench for joy_to_ps2_key: a default build plus a GAP_CYCLES=1, FIFO_DEPTH=2 build,
// each with an expected-word queue drained by a negedge monitor.
module tb_joy_to_ps2_key;
  import bridge_keys_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [11:0] btn = '0;
  logic [11:0] btn_b = '0;
  logic [10:0] ps2_key, ps2_key_b;
  logic busy, busy_b;
  logic [3:0] fifo_lvl;
  logic [1:0] fifo_lvl_b;
  emit_state_e dbg_a, dbg_b;

  joy_to_ps2_key #(.NUM_BTN(12), .FIFO_DEPTH(8), .GAP_CYCLES(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .btn(btn), .ps2_key(ps2_key),
    .busy(busy), .fifo_lvl(fifo_lvl), .dbg_state(dbg_a)
  );

  joy_to_ps2_key #(.NUM_BTN(12), .FIFO_DEPTH(2), .GAP_CYCLES(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .btn(btn_b), .ps2_key(ps2_key_b),
    .busy(busy_b), .fifo_lvl(fifo_lvl_b), .dbg_state(dbg_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] codes [12] = '{8'h1C, 8'h1A, 8'h2A, 8'h2B, 8'h1B, 8'h22,
                             8'h14, 8'h66, 8'h23, 8'h21, 8'h16, 8'h11};

  logic [10:0] exp_q[$];
  logic [10:0] exp_b_q[$];
  logic tog_a = 1'b0;
  logic tog_b = 1'b0;

  // stimulus-owned request flags/counters
  bit chk_quiet = 1'b0;
  bit busy_chk = 1'b0;
  bit gap_chk_a = 1'b0;
  int lat_start = 0, lat_req = 0, gap_epoch = 0, b_epoch = 0;
  int rst_req = 0, full_req = 0, to_req = 0, fin_req = 0;

  // checker-owned state
  int errors = 0, checks = 0;
  int lat_done = 0, gap_seen = 0, b_seen = 0, rst_done = 0, full_done = 0, to_done = 0, fin_done = 0;
  int last_tog_a = -1, last_tog_b = -1, b_cnt = 0, max_lvl_a = 0;
  logic [10:0] prev_a = '0, prev_b = '0, e, eb;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_a = ps2_key;
      prev_b = ps2_key_b;
      if (rst_req != rst_done) begin
        rst_done = rst_req;
        chk(ps2_key == 11'h000 && !busy && fifo_lvl == 4'd0 && dbg_a == IDLE,
            "async_reset", 32'({ps2_key, busy, fifo_lvl}), 32'h0);
      end
    end else begin
      if (chk_quiet)
        chk(ps2_key == 11'h000 && !busy && fifo_lvl == 4'd0,
            "idle_quiet", 32'({ps2_key, busy, fifo_lvl}), 32'h0);
      if (int'(fifo_lvl) > max_lvl_a) max_lvl_a = int'(fifo_lvl);
      if (ps2_key != prev_a) begin
        chk(exp_q.size() != 0, "unexpected_a", 32'(ps2_key), 32'h0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(ps2_key == e, "ps2_key_a", 32'(ps2_key), 32'(e));
        end
        if (lat_req != lat_done) begin
          lat_done = lat_req;
          chk(cyc - lat_start == 3, "latency", 32'(cyc - lat_start), 32'd3);
        end
        if (gap_epoch != gap_seen) gap_seen = gap_epoch;
        else if (gap_chk_a) chk(cyc - last_tog_a == 16, "gap_a", 32'(cyc - last_tog_a), 32'd16);
        last_tog_a = cyc;
      end
      if (busy_chk && last_tog_a >= 0) begin
        if (cyc == last_tog_a + 1)  chk(busy == 1'b1, "busy_hold", 32'(busy), 32'd1);
        if (cyc == last_tog_a + 16) chk(busy == 1'b0, "busy_drop", 32'(busy), 32'd0);
      end
      if (ps2_key_b != prev_b) begin
        chk(exp_b_q.size() != 0, "unexpected_b", 32'(ps2_key_b), 32'h0);
        if (exp_b_q.size() != 0) begin
          eb = exp_b_q.pop_front();
          chk(ps2_key_b == eb, "ps2_key_b", 32'(ps2_key_b), 32'(eb));
        end
        if (b_epoch != b_seen) begin
          b_seen = b_epoch;
          b_cnt = 0;
        end
        b_cnt++;
        if (b_cnt > 1) chk(cyc - last_tog_b == 1, "gap_b", 32'(cyc - last_tog_b), 32'd1);
        chk(fifo_lvl_b == ((b_cnt < 12) ? 2'd1 : 2'd0), "lvl_b", 32'(fifo_lvl_b), (b_cnt < 12) ? 32'd1 : 32'd0);
        last_tog_b = cyc;
      end
      if (full_req != full_done) begin
        full_done = full_req;
        chk(max_lvl_a == 8, "fifo_peak", 32'(max_lvl_a), 32'd8);
      end
      if (to_req != to_done) begin
        to_done = to_req;
        checks++;
        errors++;
        $display("FAIL timeout: got %0d expired waits expected 0 at cycle %0d", to_req, cyc);
      end
      if (fin_req != fin_done) begin
        fin_done = fin_req;
        chk(exp_q.size() == 0, "drain_a", 32'(exp_q.size()), 32'd0);
        chk(exp_b_q.size() == 0, "drain_b", 32'(exp_b_q.size()), 32'd0);
      end
      prev_a = ps2_key;
      prev_b = ps2_key_b;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic exp_a(input int idx, input bit pr);
    tog_a = ~tog_a;
    exp_q.push_back({tog_a, pr, 1'b0, codes[idx]});
  endtask

  task automatic exp_b(input int idx, input bit pr);
    tog_b = ~tog_b;
    exp_b_q.push_back({tog_b, pr, 1'b0, codes[idx]});
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    tick(3);
    while (busy && n < limit) begin
      tick(1);
      n++;
    end
    if (busy) to_req++;
    tick(2);
  endtask

  task automatic wait_lvl(input int lvl, input bit need_gap);
    int n;
    n = 0;
    while (!(int'(fifo_lvl) == lvl && (!need_gap || dbg_a == GAP)) && n < 100) begin
      tick(1);
      n++;
    end
    if (!(int'(fifo_lvl) == lvl && (!need_gap || dbg_a == GAP))) to_req++;
  endtask

  initial begin
    chk_quiet = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(100);
    chk_quiet = 1'b0;

    // single press / release with hand-computed words
    busy_chk = 1'b1;
    lat_start = cyc;
    lat_req++;
    exp_q.push_back(11'h61C);
    btn[0] = 1'b1;
    wait_idle(200);
    exp_q.push_back(11'h01C);
    btn[0] = 1'b0;
    wait_idle(200);
    busy_chk = 1'b0;
    tog_a = 1'b0;

    // all twelve at once: index order, 16-cycle pacing, FIFO saturates at 8
    gap_epoch++;
    gap_chk_a = 1'b1;
    for (int i = 0; i < 12; i++) exp_a(i, 1'b1);
    btn = 12'hFFF;
    wait_idle(600);
    gap_chk_a = 1'b0;
    full_req++;
    for (int i = 0; i < 12; i++) exp_a(i, 1'b0);
    btn = 12'h000;
    wait_idle(600);

    // btn[7] glitch while full is swallowed, then a clean pulse on an empty FIFO
    for (int i = 0; i < 12; i++) if (i != 7) exp_a(i, 1'b1);
    btn = 12'hF7F;
    wait_lvl(8, 1'b0);
    btn[7] = 1'b1;
    tick(1);
    btn[7] = 1'b0;
    wait_idle(600);
    for (int i = 0; i < 12; i++) if (i != 7) exp_a(i, 1'b0);
    btn = 12'h000;
    wait_idle(600);
    exp_a(7, 1'b1);
    exp_a(7, 1'b0);
    btn[7] = 1'b1;
    tick(1);
    btn[7] = 1'b0;
    wait_idle(200);

    // reset in the middle of a burst, then held buttons re-emit
    for (int i = 0; i < 12; i++) exp_a(i, 1'b1);
    btn = 12'hFFF;
    wait_lvl(5, 1'b1);
    #1;
    reset_n = 1'b0;
    rst_req++;
    exp_q.delete();
    tog_a = 1'b0;
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) exp_a(i, 1'b1);
    wait_idle(600);

    // fast build: one toggle per cycle once the pipeline fills
    b_epoch++;
    for (int i = 0; i < 12; i++) exp_b(i, 1'b1);
    btn_b = 12'hFFF;
    begin
      int n;
      n = 0;
      tick(3);
      while (busy_b && n < 100) begin
        tick(1);
        n++;
      end
      if (busy_b) to_req++;
      tick(2);
    end

    fin_req++;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
